// File: rtl/swu_buffer_scheduler.sv
// ============================================================================
// Module   : swu_buffer_scheduler
// Brief    : Frame sequencer, single-port arbiter and credit tracker for the
//            SWU circular line buffer. Optional stall counters are enabled
//            by defining SWU_BUFFER_SCHEDULER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module swu_buffer_scheduler #(
    parameter int BUFFER_DEPTH = 20,
    parameter int PREFILL      = 12,
    parameter int FRAME_WORDS  = 1024,
    parameter int AW           = $clog2(BUFFER_DEPTH)
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          wr_req,
    output logic          wr_gnt,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_last,
    output logic          rd_gnt,
    input  logic          rd_free,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW:0]   occupancy,
    output logic          frame_done,
    output logic          err
`ifdef SWU_BUFFER_SCHEDULER_STATS_EN
    ,
    output logic [31:0]   wr_stall_cnt,
    output logic [31:0]   rd_stall_cnt
`endif
);

    localparam int WCW = $clog2(FRAME_WORDS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic GNT_WR = 1'b0;
    localparam logic GNT_RD = 1'b1;

    localparam logic [AW-1:0] PTR_MAX     = AW'(BUFFER_DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [AW:0]   OCC_FULL    = (AW+1)'(BUFFER_DEPTH);
    localparam logic [AW:0]   OCC_ONE     = (AW+1)'(1);
    localparam logic [WCW-1:0] CNT_PREFILL = WCW'(PREFILL);
    localparam logic [WCW-1:0] CNT_FRAME   = WCW'(FRAME_WORDS);
    localparam logic [WCW-1:0] CNT_ONE     = WCW'(1);

    logic [2:0]     state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [WCW-1:0] wr_count_q, wr_count_d;
    logic [AW:0]    occupancy_q, occupancy_d;
    logic           last_gnt_q, last_gnt_d;
    logic           mem_en_q, mem_en_d;
    logic           mem_we_q, mem_we_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic           err_q, err_d;
    logic           write_ok, read_ok;

    // State register and datapath flops
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            wr_count_q  <= '0;
            occupancy_q <= '0;
            last_gnt_q  <= GNT_RD;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_count_q  <= wr_count_d;
            occupancy_q <= occupancy_d;
            last_gnt_q  <= last_gnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FILL;
            S_FILL:  if (wr_count_d >= CNT_PREFILL) state_d = S_RUN;
            S_RUN:   if (wr_count_d == CNT_FRAME)   state_d = S_DRAIN;
            S_DRAIN: if (rd_gnt && rd_last)         state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: eligibility, round-robin grant, frame strobe
    always_comb begin
        write_ok   = wr_req && (occupancy_q < OCC_FULL) &&
                     (state_q == S_FILL || state_q == S_RUN);
        read_ok    = rd_req && (state_q == S_RUN || state_q == S_DRAIN);
        wr_gnt     = write_ok && (!read_ok || last_gnt_q == GNT_RD);
        rd_gnt     = read_ok && (!write_ok || last_gnt_q == GNT_WR);
        frame_done = (state_q == S_DONE);
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_count_d  = wr_count_q;
        last_gnt_d  = last_gnt_q;
        occupancy_d = occupancy_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        err_d       = err_q;

        if (state_q == S_IDLE) begin
            wr_ptr_d   = '0;
            wr_count_d = '0;
            last_gnt_d = GNT_RD;
        end else if (wr_gnt) begin
            wr_ptr_d   = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_ONE;
            if (wr_count_q != CNT_FRAME) wr_count_d = wr_count_q + CNT_ONE;
            last_gnt_d = GNT_WR;
            mem_en_d   = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = wr_ptr_q;
        end else if (rd_gnt) begin
            last_gnt_d = GNT_RD;
            mem_en_d   = 1'b1;
            mem_addr_d = rd_addr;
        end

        // A free that coincides with a write cancels it, even from empty
        if (wr_gnt && !rd_free) begin
            occupancy_d = occupancy_q + OCC_ONE;
        end else if (!wr_gnt && rd_free) begin
            if (occupancy_q != '0) occupancy_d = occupancy_q - OCC_ONE;
            else                   err_d       = 1'b1;
        end

        if (rd_gnt && rd_last && state_q == S_RUN) err_d = 1'b1;
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign occupancy = occupancy_q;
    assign err       = err_q;

`ifdef SWU_BUFFER_SCHEDULER_STATS_EN
    logic [31:0] wr_stall_cnt_q, wr_stall_cnt_d;
    logic [31:0] rd_stall_cnt_q, rd_stall_cnt_d;

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_stall_cnt_q <= '0;
            rd_stall_cnt_q <= '0;
        end else begin
            wr_stall_cnt_q <= wr_stall_cnt_d;
            rd_stall_cnt_q <= rd_stall_cnt_d;
        end
    end

    always_comb begin
        wr_stall_cnt_d = wr_stall_cnt_q;
        rd_stall_cnt_d = rd_stall_cnt_q;
        if (state_q == S_IDLE) begin
            wr_stall_cnt_d = '0;
            rd_stall_cnt_d = '0;
        end else begin
            if (wr_req && !wr_gnt && wr_stall_cnt_q != 32'hFFFF_FFFF)
                wr_stall_cnt_d = wr_stall_cnt_q + 32'd1;
            if (rd_req && !rd_gnt && rd_stall_cnt_q != 32'hFFFF_FFFF)
                rd_stall_cnt_d = rd_stall_cnt_q + 32'd1;
        end
    end

    assign wr_stall_cnt = wr_stall_cnt_q;
    assign rd_stall_cnt = rd_stall_cnt_q;
`else
    // Stall statistics not built in this configuration
`endif

endmodule

`default_nettype wire

// File: tb/tb_swu_buffer_scheduler.sv
// ============================================================================
// Module   : tb_swu_buffer_scheduler
// Brief    : Directed self-checking bench for swu_buffer_scheduler
//            (BUFFER_DEPTH=8, PREFILL=4, FRAME_WORDS=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_swu_buffer_scheduler;

    localparam int BD = 8;
    localparam int PF = 4;
    localparam int FW = 16;
    localparam int AW = 3;

    logic          aclk = 1'b0;
    logic          areset;
    logic          wr_req, rd_req, rd_last, rd_free;
    logic [AW-1:0] rd_addr;
    logic          wr_gnt, rd_gnt, mem_en, mem_we, frame_done, err;
    logic [AW-1:0] mem_addr;
    logic [AW:0]   occupancy;
`ifdef SWU_BUFFER_SCHEDULER_STATS_EN
    logic [31:0]   wr_stall_cnt, rd_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int fd_count = 0;
    int exp_ptr;

    always #5 aclk = ~aclk;

    always @(posedge aclk) if (frame_done) fd_count <= fd_count + 1;

    swu_buffer_scheduler #(
        .BUFFER_DEPTH (BD),
        .PREFILL      (PF),
        .FRAME_WORDS  (FW)
    ) u_dut (
        .aclk         (aclk),
        .areset       (areset),
        .wr_req       (wr_req),
        .wr_gnt       (wr_gnt),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_last      (rd_last),
        .rd_gnt       (rd_gnt),
        .rd_free      (rd_free),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .occupancy    (occupancy),
        .frame_done   (frame_done),
        .err          (err)
`ifdef SWU_BUFFER_SCHEDULER_STATS_EN
        ,
        .wr_stall_cnt (wr_stall_cnt),
        .rd_stall_cnt (rd_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [AW-1:0] a,
                         input logic l, input logic f);
        wr_req  = w;
        rd_req  = r;
        rd_addr = a;
        rd_last = l;
        rd_free = f;
        #1;
    endtask

    initial begin
        areset = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        step();
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_frame_done", 32'(frame_done), 0);

        // IDLE cycle, then FILL with only the reader asking
        areset = 1'b0;
        drive(0, 1, 5, 0, 0);
        chk("idle_wr_gnt", 32'(wr_gnt), 0);
        chk("idle_rd_gnt", 32'(rd_gnt), 0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("fill_rd_blocked", 32'(rd_gnt), 0);
            step();
        end
`ifdef SWU_BUFFER_SCHEDULER_STATS_EN
        chk("rd_stall_fill", rd_stall_cnt, 5);
`endif

        drive(1, 1, 5, 0, 0);
        for (int i = 0; i < PF; i++) begin
            chk("fill_wr_gnt", 32'(wr_gnt), 1);
            chk("fill_rd_gnt", 32'(rd_gnt), 0);
            step();
            chk("fill_mem_en", 32'(mem_en), 1);
            chk("fill_mem_we", 32'(mem_we), 1);
            chk("fill_mem_addr", 32'(mem_addr), 32'(i));
        end
        chk("prefill_occ", 32'(occupancy), 4);

        // RUN: alternate R/W until full, then reads only
        exp_ptr = 4;
        for (int k = 0; k < 10; k++) begin
            logic ew;
            ew = (k < 8) && (k % 2 == 1);
            chk("run_wr_gnt", 32'(wr_gnt), 32'(ew));
            chk("run_rd_gnt", 32'(rd_gnt), 32'(!ew));
            step();
            chk("run_mem_we", 32'(mem_we), 32'(ew));
            chk("run_mem_addr", 32'(mem_addr), ew ? 32'(exp_ptr) : 32'd5);
            if (ew) exp_ptr = (exp_ptr + 1) % BD;
        end
        chk("full_occ", 32'(occupancy), 8);
`ifdef SWU_BUFFER_SCHEDULER_STATS_EN
        chk("wr_stall_run", wr_stall_cnt, 6);
`endif

        drive(1, 0, 5, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("full_blocks_wr", 32'(wr_gnt), 0);
            step();
        end
        chk("full_mem_en", 32'(mem_en), 0);
`ifdef SWU_BUFFER_SCHEDULER_STATS_EN
        chk("wr_stall_full", wr_stall_cnt, 9);
`endif

        drive(0, 0, 5, 0, 1);
        step();
        chk("free_occ", 32'(occupancy), 7);
        drive(1, 0, 5, 0, 0);
        chk("refill_wr_gnt", 32'(wr_gnt), 1);
        step();
        chk("wrap_mem_addr", 32'(mem_addr), 0);
        chk("refill_occ", 32'(occupancy), 8);

        drive(0, 0, 5, 0, 1);
        repeat (3) step();
        chk("occ_5", 32'(occupancy), 5);
        drive(1, 0, 5, 0, 1);
        chk("wr_free_gnt", 32'(wr_gnt), 1);
        step();
        chk("wr_free_occ", 32'(occupancy), 5);
        chk("wr_free_addr", 32'(mem_addr), 1);

        drive(0, 0, 5, 0, 1);
        repeat (5) step();
        chk("empty_occ", 32'(occupancy), 0);
        chk("no_err_yet", 32'(err), 0);
        step();
        chk("underflow_err", 32'(err), 1);
        chk("underflow_occ", 32'(occupancy), 0);

        // Remaining 6 writes of the frame take it into DRAIN
        drive(1, 0, 5, 0, 0);
        for (int i = 0; i < 6; i++) begin
            chk("tail_wr_gnt", 32'(wr_gnt), 1);
            step();
        end
        chk("drain_occ", 32'(occupancy), 6);
        chk("drain_no_wr", 32'(wr_gnt), 0);

        drive(0, 1, 3, 0, 0);
        chk("drain_rd_gnt", 32'(rd_gnt), 1);
        step();
        chk("drain_mem_addr", 32'(mem_addr), 3);
        chk("drain_mem_we", 32'(mem_we), 0);
        drive(0, 1, 3, 1, 0);
        chk("last_rd_gnt", 32'(rd_gnt), 1);
        step();
        chk("frame_done_hi", 32'(frame_done), 1);
        drive(1, 0, 0, 0, 0);
        chk("done_no_wr", 32'(wr_gnt), 0);
        step();
        chk("frame_done_lo", 32'(frame_done), 0);
        chk("idle2_no_wr", 32'(wr_gnt), 0);
        step();
        chk("frame2_wr_gnt", 32'(wr_gnt), 1);
        step();
        chk("frame2_mem_addr", 32'(mem_addr), 0);
        chk("frame2_occ", 32'(occupancy), 7);
        chk("err_sticky", 32'(err), 1);
        chk("fd_count_1", 32'(fd_count), 1);

        // Reset in RUN at wr_count=9
        areset = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        chk("rst2_err", 32'(err), 0);
        areset = 1'b0;
        drive(1, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 0, 0, (i >= 4));
            step();
        end
        chk("pre_rst_occ", 32'(occupancy), 4);
        areset = 1'b1;
        drive(1, 1, 2, 1, 1);
        step();
        chk("midrst_occ", 32'(occupancy), 0);
        chk("midrst_mem_en", 32'(mem_en), 0);
        chk("midrst_mem_we", 32'(mem_we), 0);
        chk("midrst_mem_addr", 32'(mem_addr), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_frame_done", 32'(frame_done), 0);
        chk("midrst_wr_gnt", 32'(wr_gnt), 0);
        chk("midrst_rd_gnt", 32'(rd_gnt), 0);

        // rd_last granted in RUN flags an error but keeps RUN
        areset = 1'b0;
        drive(1, 0, 0, 0, 0);
        step();
        repeat (PF) step();
        drive(0, 1, 2, 1, 0);
        chk("early_last_gnt", 32'(rd_gnt), 1);
        step();
        chk("early_last_err", 32'(err), 1);
        chk("early_last_no_done", 32'(frame_done), 0);
        drive(1, 0, 0, 0, 0);
        chk("still_run_wr", 32'(wr_gnt), 1);
        step();
        chk("fd_count_final", 32'(fd_count), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/swu_buffer_scheduler.md
Name: swu_buffer_scheduler

Overview:
- Sequences one sliding-window frame through the SWU circular line buffer.
- Arbitrates the buffer's single memory port between the input writer and the window reader.
- Tracks buffer occupancy as credits so the writer never overruns words the reader still needs.
- Sits between the input AXI-stream write logic, the read-address generator and the buffer RAM.

Parameters:
- BUFFER_DEPTH, 20, buffer words; any value >= 2, not necessarily a power of two.
- PREFILL, 12, words written before the first read is allowed; 1..BUFFER_DEPTH.
- FRAME_WORDS, 1024, words written per frame (IFM pixels × WORDS_PER_PX); >= PREFILL.
- AW, $clog2(BUFFER_DEPTH), address width.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- wr_req  in  1  writer has a word to store.
- wr_gnt  out  1  write granted this cycle (combinational).
- rd_req  in  1  reader requests a read at rd_addr.
- rd_addr  in  AW  read address supplied by the reader.
- rd_last  in  1  qualifies rd_req: final read of the frame.
- rd_gnt  out  1  read granted this cycle (combinational).
- rd_free  in  1  pulse: reader releases one word (independent of rd_gnt).
- mem_en  out  1  RAM enable (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_addr  out  AW  RAM address (registered).
- occupancy  out  AW+1  words held, not yet freed.
- frame_done  out  1  one-cycle pulse at frame end.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (sync, areset=1): state=IDLE; wr_ptr=0, wr_count=0, occupancy=0, last_gnt=READ; mem_en=mem_we=0, mem_addr=0; frame_done=0, err=0. Reset mid-frame aborts the frame immediately; no frame_done is produced.
- State IDLE: one cycle, clears wr_ptr/wr_count/last_gnt; grants nothing; -> FILL.
- State FILL: only writes eligible; -> RUN on the cycle wr_count reaches PREFILL (counting that cycle's grant).
- State RUN: writes and reads both eligible; -> DRAIN on the cycle wr_count reaches FRAME_WORDS.
- State DRAIN: only reads eligible; -> DONE when rd_gnt && rd_last.
- State DONE: frame_done=1 for exactly this cycle; -> IDLE. Occupancy is not cleared here; rd_free pulses may still arrive.
- Eligibility:
  - write_ok = wr_req && occupancy < BUFFER_DEPTH && state in {FILL, RUN}.
  - read_ok = rd_req && state in {RUN, DRAIN}.
- Arbitration: one grant per cycle. If only one side is eligible, grant it. If both are eligible, grant the side opposite last_gnt (round robin). last_gnt updates only on a grant. wr_gnt and rd_gnt are never both 1.
- Memory port:
  - On wr_gnt: next cycle mem_en=1, mem_we=1, mem_addr=wr_ptr.
  - On rd_gnt: next cycle mem_en=1, mem_we=0, mem_addr=rd_addr.
  - Otherwise mem_en=0, mem_we=0, mem_addr holds.
  - Latency: grant to RAM strobe is 1 cycle.
- wr_ptr: +1 per wr_gnt, wraps BUFFER_DEPTH-1 -> 0 by compare, not modulo-2^AW.
- wr_count: +1 per wr_gnt; saturates at FRAME_WORDS.
- occupancy:
  - +1 on wr_gnt, -1 on rd_free; both in the same cycle leaves it unchanged.
  - rd_free with occupancy=0 (and no write grant that cycle) is ignored and sets err.
- occupancy=BUFFER_DEPTH blocks writes (wr_gnt=0) even when the reader is idle; reads are still granted.
- rd_req in FILL or IDLE: not granted, no error; reader must hold the request.
- rd_last granted in RUN (before all writes are done): sets err; state is unaffected.
- err clears only on reset.

Optional Feature:
- Macro: SWU_BUFFER_SCHEDULER_STATS_EN.
- When defined:
  - Adds outputs wr_stall_cnt[31:0] and rd_stall_cnt[31:0].
  - Each counts cycles where its request was asserted but not granted, in any state.
  - Both counters saturate at 2^32-1 and clear on reset and in IDLE.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- All tests use BUFFER_DEPTH=8, PREFILL=4, FRAME_WORDS=16.
- Reset then wr_req held high, rd_req held high -> first 4 grants are writes (mem_addr 0..3, mem_we=1 one cycle after each); rd_gnt=0 until RUN; occupancy=4.
- RUN with both requests held, no rd_free -> grants alternate W/R until occupancy=8; then only rd_gnt; wr_gnt=0 and wr_ptr wrapped 7->0 at the 8th write.
- wr_gnt and rd_free in the same cycle at occupancy=5 -> occupancy stays 5; rd_free at occupancy=0 -> err=1 and occupancy stays 0.
- Full frame: 16 writes, then rd_req+rd_last in DRAIN -> frame_done high exactly 1 cycle after the rd_last grant, then IDLE, then FILL; second frame restarts at mem_addr 0.
- areset asserted in RUN at wr_count=9 -> next cycle all outputs at reset values, frame_done never pulses, err=0.
- With SWU_BUFFER_SCHEDULER_STATS_EN: rd_req held 5 cycles during FILL -> rd_stall_cnt=5; wr_req held while occupancy=8 for 3 cycles -> wr_stall_cnt increments by 3.
